// File: rtl/mips_mem_responder.sv
// Single-port word memory shared by the MIPS instruction-fetch and data (LW/SW) ports.
// Define MEM_LOAD_PORT_EN to add the ld_* preload port, which overrides both core ports.
module mips_mem_responder #(
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned DEPTH      = 1024,
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_valid_i,
    output logic              if_req_ready_o,
    input  logic [ADDR_W-1:0] if_req_addr_i,
    output logic              if_rsp_valid_o,
    input  logic              if_rsp_ready_i,
    output logic [31:0]       if_rsp_data_o,
    input  logic              dm_req_valid_i,
    output logic              dm_req_ready_o,
    input  logic              dm_req_we_i,
    input  logic [ADDR_W-1:0] dm_req_addr_i,
    input  logic [31:0]       dm_req_wdata_i,
    output logic              dm_rsp_valid_o,
    input  logic              dm_rsp_ready_i,
    output logic [31:0]       dm_rsp_data_o,
`ifdef MEM_LOAD_PORT_EN
    input  logic              ld_valid_i,
    input  logic [ADDR_W-1:0] ld_addr_i,
    input  logic [31:0]       ld_data_i,
`endif
    output logic              oor_err_o
);
    localparam int unsigned CntW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(STARVE_MAX);

    logic [31:0]       mem_q [DEPTH];
    logic              if_rsp_valid_q, if_rsp_valid_d;
    logic [31:0]       if_rsp_data_q, if_rsp_data_d;
    logic              dm_rsp_valid_q, dm_rsp_valid_d;
    logic [31:0]       dm_rsp_data_q, dm_rsp_data_d;
    logic              oor_q, oor_d;
    logic [CntW-1:0]   starve_q, starve_d;

    logic              core_blocked;
    logic              if_elig, dm_elig, force_if;
    logic              if_acc, dm_acc;
    logic              if_in, dm_in;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [31:0]       mem_wdata;

    assign if_in = 32'(if_req_addr_i) < DEPTH;
    assign dm_in = 32'(dm_req_addr_i) < DEPTH;

`ifdef MEM_LOAD_PORT_EN
    assign core_blocked = rst_i | ld_valid_i;
`else
    assign core_blocked = rst_i;
`endif

    // A stalled response register makes its port ineligible; stores never fill one.
    always_comb begin
        if_elig        = !if_rsp_valid_q || if_rsp_ready_i;
        dm_elig        = dm_req_we_i || !dm_rsp_valid_q || dm_rsp_ready_i;
        force_if       = (starve_q == CntMax) && if_elig && if_req_valid_i;
        dm_req_ready_o = !core_blocked && dm_elig && !force_if;
        if_req_ready_o = !core_blocked && if_elig && !(dm_req_valid_i && dm_req_ready_o);
        dm_acc         = dm_req_valid_i && dm_req_ready_o;
        if_acc         = if_req_valid_i && if_req_ready_o;
    end

    always_comb begin
        if_rsp_valid_d = if_rsp_valid_q && !if_rsp_ready_i;
        if_rsp_data_d  = if_rsp_data_q;
        dm_rsp_valid_d = dm_rsp_valid_q && !dm_rsp_ready_i;
        dm_rsp_data_d  = dm_rsp_data_q;
        oor_d          = (if_acc && !if_in) || (dm_acc && !dm_in);
        starve_d       = starve_q;
        if (if_acc) begin
            if_rsp_valid_d = 1'b1;
            if_rsp_data_d  = if_in ? mem_q[if_req_addr_i] : 32'h0;
        end
        if (dm_acc && !dm_req_we_i) begin
            dm_rsp_valid_d = 1'b1;
            dm_rsp_data_d  = dm_in ? mem_q[dm_req_addr_i] : 32'h0;
        end
        // Counter holds while the core ports are blocked or fetch is stalled on its own rsp.
        if (!core_blocked) begin
            if (!if_req_valid_i || if_acc) begin
                starve_d = '0;
            end else if (if_elig && starve_q != CntMax) begin
                starve_d = starve_q + 1'b1;
            end
        end
    end

    always_comb begin
        mem_we    = dm_acc && dm_req_we_i && dm_in;
        mem_waddr = dm_req_addr_i;
        mem_wdata = dm_req_wdata_i;
`ifdef MEM_LOAD_PORT_EN
        if (ld_valid_i) begin
            mem_we    = 32'(ld_addr_i) < DEPTH;
            mem_waddr = ld_addr_i;
            mem_wdata = ld_data_i;
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            if_rsp_valid_q <= 1'b0;
            if_rsp_data_q  <= 32'h0;
            dm_rsp_valid_q <= 1'b0;
            dm_rsp_data_q  <= 32'h0;
            oor_q          <= 1'b0;
            starve_q       <= '0;
        end else begin
            if_rsp_valid_q <= if_rsp_valid_d;
            if_rsp_data_q  <= if_rsp_data_d;
            dm_rsp_valid_q <= dm_rsp_valid_d;
            dm_rsp_data_q  <= dm_rsp_data_d;
            oor_q          <= oor_d;
            starve_q       <= starve_d;
        end
    end

    assign if_rsp_valid_o = if_rsp_valid_q;
    assign if_rsp_data_o  = if_rsp_data_q;
    assign dm_rsp_valid_o = dm_rsp_valid_q;
    assign dm_rsp_data_o  = dm_rsp_data_q;
    assign oor_err_o      = oor_q;

endmodule

// File: tb/tb_mips_mem_responder.sv
// Self-checking bench for mips_mem_responder: directed scenarios plus a randomized phase
// checked against a transaction-level model (memory array, pending responses, starve streak).
module tb_mips_mem_responder;
    localparam int AW    = 10;
    localparam int DEPTH = 1000;
    localparam int SMAX  = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req_valid, if_req_ready, if_rsp_valid, if_rsp_ready;
    logic [AW-1:0] if_req_addr;
    logic [31:0]   if_rsp_data;
    logic          dm_req_valid, dm_req_ready, dm_req_we, dm_rsp_valid, dm_rsp_ready;
    logic [AW-1:0] dm_req_addr;
    logic [31:0]   dm_req_wdata, dm_rsp_data;
    logic          ld_valid;
    logic [AW-1:0] ld_addr;
    logic [31:0]   ld_data;
    logic          oor_err;

    always #5 clk = ~clk;

    mips_mem_responder #(
        .ADDR_W     (AW),
        .DEPTH      (DEPTH),
        .STARVE_MAX (SMAX)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .if_req_valid_i (if_req_valid),
        .if_req_ready_o (if_req_ready),
        .if_req_addr_i  (if_req_addr),
        .if_rsp_valid_o (if_rsp_valid),
        .if_rsp_ready_i (if_rsp_ready),
        .if_rsp_data_o  (if_rsp_data),
        .dm_req_valid_i (dm_req_valid),
        .dm_req_ready_o (dm_req_ready),
        .dm_req_we_i    (dm_req_we),
        .dm_req_addr_i  (dm_req_addr),
        .dm_req_wdata_i (dm_req_wdata),
        .dm_rsp_valid_o (dm_rsp_valid),
        .dm_rsp_ready_i (dm_rsp_ready),
        .dm_rsp_data_o  (dm_rsp_data),
`ifdef MEM_LOAD_PORT_EN
        .ld_valid_i     (ld_valid),
        .ld_addr_i      (ld_addr),
        .ld_data_i      (ld_data),
`endif
        .oor_err_o      (oor_err)
    );

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model state
    logic [31:0] m_mem [1024];
    bit          m_ifv, m_dmv, m_oor;
    logic [31:0] m_ifd, m_dmd;
    int          m_lost;
    bit          obs_if_acc, obs_dm_acc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rdm(input logic [AW-1:0] a);
        return (32'(a) < DEPTH) ? m_mem[a] : 32'h0;
    endfunction

    task automatic set_if(input bit v, input int a, input bit rr);
        if_req_valid = v;
        if_req_addr  = AW'(a);
        if_rsp_ready = rr;
    endtask

    task automatic set_dm(input bit v, input bit we, input int a, input logic [31:0] d,
                          input bit rr);
        dm_req_valid = v;
        dm_req_we    = we;
        dm_req_addr  = AW'(a);
        dm_req_wdata = d;
        dm_rsp_ready = rr;
    endtask

    // One clock: inputs already driven after a negedge; predict and check, then advance.
    task automatic step();
        bit if_ok, dm_ok, forced, dm_wins, if_wins, blk;
        #1;
        blk     = ld_valid;
        if_ok   = !m_ifv || if_rsp_ready;
        dm_ok   = dm_req_we || !m_dmv || dm_rsp_ready;
        forced  = (m_lost >= SMAX) && if_ok && if_req_valid;
        dm_wins = !blk && dm_req_valid && dm_ok && !forced;
        if_wins = !blk && if_req_valid && if_ok && !dm_wins;
        if (if_req_valid) chk("if_req_ready", 32'(if_req_ready), 32'(if_wins));
        if (dm_req_valid) chk("dm_req_ready", 32'(dm_req_ready), 32'(dm_wins));
        obs_if_acc = if_req_valid && if_req_ready;
        obs_dm_acc = dm_req_valid && dm_req_ready;
        @(posedge clk);
        m_oor = 1'b0;
        if (blk && 32'(ld_addr) < DEPTH) m_mem[ld_addr] = ld_data;
        if (!blk) begin
            if (!if_req_valid || if_wins) m_lost = 0;
            else if (if_ok) m_lost = (m_lost < SMAX) ? m_lost + 1 : SMAX;
        end
        if (if_wins) begin
            m_ifv = 1'b1;
            m_ifd = rdm(if_req_addr);
            m_oor = 32'(if_req_addr) >= DEPTH;
        end else if (if_rsp_ready) begin
            m_ifv = 1'b0;
        end
        if (dm_wins && !dm_req_we) begin
            m_dmv = 1'b1;
            m_dmd = rdm(dm_req_addr);
        end else if (dm_rsp_ready) begin
            m_dmv = 1'b0;
        end
        if (dm_wins) begin
            m_oor = 32'(dm_req_addr) >= DEPTH;
            if (dm_req_we && 32'(dm_req_addr) < DEPTH) m_mem[dm_req_addr] = dm_req_wdata;
        end
        @(negedge clk);
        chk("if_rsp_valid", 32'(if_rsp_valid), 32'(m_ifv));
        if (m_ifv) chk("if_rsp_data", if_rsp_data, m_ifd);
        chk("dm_rsp_valid", 32'(dm_rsp_valid), 32'(m_dmv));
        if (m_dmv) chk("dm_rsp_data", dm_rsp_data, m_dmd);
        chk("oor_err", 32'(oor_err), 32'(m_oor));
    endtask

    task automatic idle();
        set_if(1'b0, 0, 1'b1);
        set_dm(1'b0, 1'b0, 0, 32'h0, 1'b1);
        ld_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_ifv = 0; m_dmv = 0; m_oor = 0; m_lost = 0; m_ifd = 0; m_dmd = 0;
        chk("rst_if_valid", 32'(if_rsp_valid), 32'h0);
        chk("rst_if_data", if_rsp_data, 32'h0);
        chk("rst_dm_valid", 32'(dm_rsp_valid), 32'h0);
        chk("rst_dm_data", dm_rsp_data, 32'h0);
        chk("rst_oor", 32'(oor_err), 32'h0);
    endtask

    task automatic store(input int a, input logic [31:0] d);
        set_if(1'b0, 0, 1'b1);
        set_dm(1'b1, 1'b1, a, d, 1'b1);
        step();
        set_dm(1'b0, 1'b0, 0, 32'h0, 1'b1);
    endtask

    function automatic int raddr();
        int p;
        p = $urandom_range(0, 47);
        if (p < 32) return p;
        if (p < 40) return 992 + (p - 32);
        return 1000 + (p - 40) * 3;
    endfunction

    initial begin
        int ia, da;
        logic [31:0] saved10;
        logic [31:0] lw [8];
        ld_addr = '0;
        ld_data = '0;
        do_reset();

        // Preload a known pool of words through the data port
        for (int a = 0; a < 32; a++) store(a, $urandom);
        for (int a = 992; a < 1000; a++) store(a, $urandom);
        store(5, 32'h2801000A);

        // Fetch returns the instruction one cycle later
        set_if(1'b1, 5, 1'b1);
        step();
        chk("t1_if_valid", 32'(if_rsp_valid), 32'h1);
        chk("t1_if_data", if_rsp_data, 32'h2801000A);
        chk("t1_dm_valid", 32'(dm_rsp_valid), 32'h0);
        idle();
        step();

        // Store then load the same word
        store(20, 32'hDEADBEEF);
        chk("t2_store_no_rsp", 32'(dm_rsp_valid), 32'h0);
        set_dm(1'b1, 1'b0, 20, 32'h0, 1'b1);
        step();
        chk("t2_load_valid", 32'(dm_rsp_valid), 32'h1);
        chk("t2_load_data", dm_rsp_data, 32'hDEADBEEF);
        idle();
        step();

        // Both ports busy: data wins three times, then fetch is forced through
        ia = 0;
        da = 0;
        for (int k = 0; k < 12; k++) begin
            set_if(1'b1, ia, 1'b1);
            set_dm(1'b1, 1'b0, 31 - da, 32'h0, 1'b1);
            step();
            chk("t3_fetch_win", 32'(obs_if_acc), 32'((k % 4) == 3));
            chk("t3_data_win", 32'(obs_dm_acc), 32'((k % 4) != 3));
            if (obs_if_acc) ia++;
            if (obs_dm_acc) da++;
        end
        chk("t3_fetch_count", 32'(ia), 32'd3);
        chk("t3_data_count", 32'(da), 32'd9);
        idle();
        step();

        // Fetch response back-pressure
        set_if(1'b1, 7, 1'b0);
        step();
        chk("t4_first_acc", 32'(obs_if_acc), 32'h1);
        set_if(1'b1, 8, 1'b0);
        repeat (4) begin
            step();
            chk("t4_stalled", 32'(obs_if_acc), 32'h0);
            chk("t4_held_data", if_rsp_data, m_mem[7]);
        end
        set_if(1'b1, 8, 1'b1);
        step();
        chk("t4_release_acc", 32'(obs_if_acc), 32'h1);
        chk("t4_next_data", if_rsp_data, m_mem[8]);
        idle();
        step();

        // Range boundary (DEPTH=1000)
        saved10 = m_mem[10];
        set_dm(1'b1, 1'b0, 999, 32'h0, 1'b1);
        step();
        chk("t5_last_word_oor", 32'(oor_err), 32'h0);
        set_dm(1'b1, 1'b0, 1010, 32'h0, 1'b1);
        step();
        chk("t5_oor_data", dm_rsp_data, 32'h0);
        chk("t5_oor_pulse", 32'(oor_err), 32'h1);
        idle();
        step();
        chk("t5_oor_drop", 32'(oor_err), 32'h0);
        store(1010, 32'hA5A5A5A5);
        chk("t5_store_oor", 32'(oor_err), 32'h1);
        set_dm(1'b1, 1'b0, 10, 32'h0, 1'b1);
        step();
        chk("t5_no_alias", dm_rsp_data, saved10);
        set_dm(1'b1, 1'b0, 1023, 32'h0, 1'b1);
        step();
        chk("t5_top_data", dm_rsp_data, 32'h0);
        idle();
        set_if(1'b1, 1000, 1'b1);
        step();
        chk("t5_fetch_oor", 32'(oor_err), 32'h1);
        idle();
        step();

        // Reset while both responses are stalled
        set_if(1'b1, 3, 1'b0);
        set_dm(1'b1, 1'b0, 4, 32'h0, 1'b0);
        step();
        step();
        do_reset();
        set_dm(1'b1, 1'b0, 20, 32'h0, 1'b1);
        step();
        chk("rst_mem_kept", dm_rsp_data, 32'hDEADBEEF);
        idle();
        step();

`ifdef MEM_LOAD_PORT_EN
        // Preload port blocks both core ports, then fetch sees the loaded words
        set_if(1'b1, 0, 1'b1);
        set_dm(1'b1, 1'b0, 1, 32'h0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            lw[i]    = $urandom;
            ld_valid = 1'b1;
            ld_addr  = AW'(i);
            ld_data  = lw[i];
            step();
            chk("t6_if_blocked", 32'(obs_if_acc), 32'h0);
            chk("t6_dm_blocked", 32'(obs_dm_acc), 32'h0);
        end
        ld_valid = 1'b0;
        set_dm(1'b0, 1'b0, 0, 32'h0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            set_if(1'b1, i, 1'b1);
            step();
            chk("t6_fetch_loaded", if_rsp_data, lw[i]);
        end
        idle();
        step();
`else
        lw[0] = '0;
`endif

        // Randomized traffic
        repeat (600) begin
            set_if($urandom_range(0, 3) != 0, raddr(), $urandom_range(0, 3) != 0);
            set_dm($urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0, raddr(), $urandom,
                   $urandom_range(0, 3) != 0);
            step();
        end
        idle();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
